// File: rtl/imem_boot_ctrl_if.sv
// Bundle between the UART RX / pipeline top and the instruction-memory boot
// controller.
//
// Handshake: i_rx_valid is a one-cycle strobe that qualifies i_rx_data.
// There is no ready signal; the controller samples every strobe and drops the
// bytes its current state does not accept. o_we is a one-cycle write strobe
// that qualifies o_inst_addr/o_instr_data, and the memory must accept it.
interface imem_boot_ctrl_if;
  logic        i_rx_valid;
  logic [7:0]  i_rx_data;
  logic        i_end_of_prog;
  logic        o_we;
  logic [31:0] o_inst_addr;
  logic [31:0] o_instr_data;
  logic        o_halt;
  logic        o_pipe_rst_n;
  logic        o_loaded;
  logic        o_err;
  logic [2:0]  o_state;

  // Host side: UART RX and pipeline status drive, memory/pipeline controls observed
  modport master (
    output i_rx_valid, i_rx_data, i_end_of_prog,
    input  o_we, o_inst_addr, o_instr_data, o_halt, o_pipe_rst_n,
           o_loaded, o_err, o_state
  );

  // Controller side
  modport slave (
    input  i_rx_valid, i_rx_data, i_end_of_prog,
    output o_we, o_inst_addr, o_instr_data, o_halt, o_pipe_rst_n,
           o_loaded, o_err, o_state
  );
endinterface

// File: rtl/imem_boot_ctrl.sv
// Instruction-memory boot controller: loads a program from a UART byte stream
// (big-endian words, terminated by an end-of-program word that is also stored),
// then gates the pipeline with run / single-step commands.
// Every output is a register; next values are derived from the next state.
module imem_boot_ctrl #(
  parameter int          NB_ADDR  = 8,
  parameter logic [7:0]  CMD_LOAD = 8'h4C,
  parameter logic [7:0]  CMD_RUN  = 8'h43,
  parameter logic [7:0]  CMD_STEP = 8'h53,
  parameter logic [31:0] EOP_WORD = 32'hFFFF_FFFF
) (
  input logic              clk,
  input logic              i_rst_n,
  imem_boot_ctrl_if.slave  bus
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    WRITE = 3'd2,
    RUN   = 3'd3,
    STEP  = 3'd4,
    DONE  = 3'd5
  } state_e;

  // Last word-aligned address; a non-EOP word written here means overflow
  localparam logic [NB_ADDR-1:0] ADDR_LAST = {{(NB_ADDR-2){1'b1}}, 2'b00};
  localparam logic [NB_ADDR-1:0] ADDR_STEP = NB_ADDR'(4);

  state_e             state_q, state_d;
  logic [NB_ADDR-1:0] addr_q, addr_d;
  logic [1:0]         cnt_q, cnt_d;
  logic [31:0]        word_q, word_d;
  logic [31:0]        data_q, data_d;
  logic               we_q, we_d;
  logic               halt_q, halt_d;
  logic               pipe_rst_n_q, pipe_rst_n_d;
  logic               loaded_q, loaded_d;
  logic               err_q, err_d;

  // Next-state and next-output logic
  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    cnt_d        = cnt_q;
    word_d       = word_q;
    data_d       = data_q;
    loaded_d     = loaded_q;
    err_d        = err_q;
    we_d         = 1'b0;
    halt_d       = 1'b1;
    pipe_rst_n_d = 1'b0;

    case (state_q)
      IDLE, DONE: begin
        if (bus.i_rx_valid) begin
          if (bus.i_rx_data == CMD_LOAD) begin
            state_d  = LOAD;
            cnt_d    = 2'd0;
            addr_d   = '0;
            loaded_d = 1'b0;
            err_d    = 1'b0;
          end else if (bus.i_rx_data == CMD_RUN || bus.i_rx_data == CMD_STEP) begin
            // DONE always refuses: the program must be reloaded first
            if (state_q == IDLE && loaded_q) begin
              state_d = (bus.i_rx_data == CMD_RUN) ? RUN : STEP;
            end else begin
              err_d = 1'b1;
            end
          end
        end
      end
      LOAD: begin
        if (bus.i_rx_valid) begin
          word_d = {word_q[23:0], bus.i_rx_data};
          if (cnt_q == 2'd3) begin
            data_d  = {word_q[23:0], bus.i_rx_data};
            cnt_d   = 2'd0;
            state_d = WRITE;
          end else begin
            cnt_d = cnt_q + 2'd1;
          end
        end
      end
      WRITE: begin
        if (data_q == EOP_WORD) begin
          loaded_d = 1'b1;
          addr_d   = '0;
          state_d  = IDLE;
        end else if (addr_q == ADDR_LAST) begin
          err_d    = 1'b1;
          loaded_d = 1'b0;
          addr_d   = '0;
          state_d  = IDLE;
        end else begin
          addr_d  = addr_q + ADDR_STEP;
          state_d = LOAD;
        end
      end
      RUN: begin
        if (bus.i_end_of_prog) state_d = DONE;
      end
      STEP: begin
        state_d = bus.i_end_of_prog ? DONE : IDLE;
      end
      default: state_d = IDLE;
    endcase

    we_d         = (state_d == WRITE);
    halt_d       = !(state_d == RUN || state_d == STEP);
    pipe_rst_n_d = (state_d == LOAD || state_d == WRITE) ? 1'b0 : loaded_d;
  end

  // State and output registers; reset aborts any load in progress
  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q      <= IDLE;
      addr_q       <= '0;
      cnt_q        <= 2'd0;
      word_q       <= 32'd0;
      data_q       <= 32'd0;
      we_q         <= 1'b0;
      halt_q       <= 1'b1;
      pipe_rst_n_q <= 1'b0;
      loaded_q     <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      cnt_q        <= cnt_d;
      word_q       <= word_d;
      data_q       <= data_d;
      we_q         <= we_d;
      halt_q       <= halt_d;
      pipe_rst_n_q <= pipe_rst_n_d;
      loaded_q     <= loaded_d;
      err_q        <= err_d;
    end
  end

  assign bus.o_we         = we_q;
  assign bus.o_inst_addr  = {{(32-NB_ADDR){1'b0}}, addr_q};
  assign bus.o_instr_data = data_q;
  assign bus.o_halt       = halt_q;
  assign bus.o_pipe_rst_n = pipe_rst_n_q;
  assign bus.o_loaded     = loaded_q;
  assign bus.o_err        = err_q;
  assign bus.o_state      = state_q;

endmodule

// File: tb/tb_imem_boot_ctrl.sv
// Directed bench for imem_boot_ctrl: memory writes are checked against a
// queue of expected {address, data} pairs filled as words are sent.
module tb_imem_boot_ctrl;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic i_rst_n = 1'b0;
  always #5 clk = ~clk;

  imem_boot_ctrl_if bus();

  imem_boot_ctrl dut (
    .clk     (clk),
    .i_rst_n (i_rst_n),
    .bus     (bus)
  );

  // ---------------- scoreboard ----------------
  logic [63:0] exp_q[$];
  int n_checks = 0;
  int n_pass   = 0;
  int wr_cnt   = 0;
  int halt_low = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  // Every write strobe must match the oldest expected write
  always @(negedge clk) begin
    if (bus.o_we === 1'b1) begin
      wr_cnt++;
      if (exp_q.size() == 0) begin
        check("unexpected_write_addr", bus.o_inst_addr, 32'hDEAD_0000);
      end else begin
        logic [63:0] e;
        e = exp_q.pop_front();
        check("write_addr", bus.o_inst_addr, e[63:32]);
        check("write_data", bus.o_instr_data, e[31:0]);
        check("write_pipe_rst_n", {31'd0, bus.o_pipe_rst_n}, 32'd0);
      end
    end
    if (bus.o_halt === 1'b0) halt_low++;
  end

  // ---------------- driver tasks ----------------
  task automatic send_byte(input logic [7:0] b);
    @(posedge clk); #1;
    bus.i_rx_valid = 1'b1;
    bus.i_rx_data  = b;
    @(posedge clk); #1;
    bus.i_rx_valid = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w, input logic [31:0] addr);
    exp_q.push_back({addr, w});
    send_byte(w[31:24]);
    send_byte(w[23:16]);
    send_byte(w[15:8]);
    send_byte(w[7:0]);
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_we"},    {31'd0, bus.o_we}, 32'd0);
    check({tag, "_addr"},  bus.o_inst_addr, 32'd0);
    check({tag, "_data"},  bus.o_instr_data, 32'd0);
    check({tag, "_halt"},  {31'd0, bus.o_halt}, 32'd1);
    check({tag, "_prst"},  {31'd0, bus.o_pipe_rst_n}, 32'd0);
    check({tag, "_load"},  {31'd0, bus.o_loaded}, 32'd0);
    check({tag, "_err"},   {31'd0, bus.o_err}, 32'd0);
    check({tag, "_state"}, {29'd0, bus.o_state}, 32'd0);
  endtask

  task automatic do_reset();
    #1;
    i_rst_n = 1'b0;
    bus.i_rx_valid    = 1'b0;
    bus.i_rx_data     = 8'h00;
    bus.i_end_of_prog = 1'b0;
    idle_cycles(2);
    i_rst_n = 1'b1;
    idle_cycles(1);
  endtask

  task automatic load_prog();
    send_byte(8'h4C);
    send_word(32'h0000_0020, 32'd0);
    send_word(32'h0001_0820, 32'd4);
    send_word(32'hFFFF_FFFF, 32'd8);
    idle_cycles(3);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int wr_base;
    bus.i_rx_valid    = 1'b0;
    bus.i_rx_data     = 8'h00;
    bus.i_end_of_prog = 1'b0;

    // 1: reset values, then a three-word load
    do_reset();
    check_reset_vals("rst");
    send_byte(8'h4C);
    check("load_state", {29'd0, bus.o_state}, 32'd1);
    check("load_prst", {31'd0, bus.o_pipe_rst_n}, 32'd0);
    send_word(32'h0000_0020, 32'd0);
    send_word(32'h0001_0820, 32'd4);
    send_word(32'hFFFF_FFFF, 32'd8);
    idle_cycles(3);
    check("load_loaded", {31'd0, bus.o_loaded}, 32'd1);
    check("load_prst_after", {31'd0, bus.o_pipe_rst_n}, 32'd1);
    check("load_state_idle", {29'd0, bus.o_state}, 32'd0);
    check("load_wr_cnt", wr_cnt, 32'd3);
    check("load_q_empty", exp_q.size(), 32'd0);

    // 2: run until end of program
    check("run_halt_before", {31'd0, bus.o_halt}, 32'd1);
    send_byte(8'h43);
    check("run_halt", {31'd0, bus.o_halt}, 32'd0);
    check("run_state", {29'd0, bus.o_state}, 32'd3);
    send_byte(8'h4C);  // ignored while running
    idle_cycles(8);
    check("run_halt_hold", {31'd0, bus.o_halt}, 32'd0);
    check("run_state_hold", {29'd0, bus.o_state}, 32'd3);
    bus.i_end_of_prog = 1'b1;
    idle_cycles(1);
    bus.i_end_of_prog = 1'b0;
    check("done_halt", {31'd0, bus.o_halt}, 32'd1);
    check("done_state", {29'd0, bus.o_state}, 32'd5);
    send_byte(8'h43);
    check("done_run_err", {31'd0, bus.o_err}, 32'd1);
    check("done_run_state", {29'd0, bus.o_state}, 32'd5);

    // 3: reload (clears error), then three single steps
    load_prog();
    check("reload_err", {31'd0, bus.o_err}, 32'd0);
    check("reload_loaded", {31'd0, bus.o_loaded}, 32'd1);
    halt_low = 0;
    for (int i = 0; i < 3; i++) begin
      send_byte(8'h53);
      check("step_state", {29'd0, bus.o_state}, 32'd4);
      check("step_halt", {31'd0, bus.o_halt}, 32'd0);
      idle_cycles(1);
      check("step_back_state", {29'd0, bus.o_state}, 32'd0);
      check("step_back_halt", {31'd0, bus.o_halt}, 32'd1);
    end
    idle_cycles(2);
    check("step_pulses", halt_low, 32'd3);
    // step that retires the halt instruction
    send_byte(8'h53);
    bus.i_end_of_prog = 1'b1;
    idle_cycles(1);
    bus.i_end_of_prog = 1'b0;
    check("step_eop_state", {29'd0, bus.o_state}, 32'd5);

    // 4: run with nothing loaded
    do_reset();
    wr_base = wr_cnt;
    send_byte(8'h43);
    idle_cycles(2);
    check("noprog_err", {31'd0, bus.o_err}, 32'd1);
    check("noprog_halt", {31'd0, bus.o_halt}, 32'd1);
    check("noprog_state", {29'd0, bus.o_state}, 32'd0);
    check("noprog_nowr", wr_cnt - wr_base, 32'd0);

    // 5: overflow with 64 non-EOP words
    do_reset();
    wr_base = wr_cnt;
    send_byte(8'h4C);
    for (int i = 0; i < 64; i++) begin
      send_word($urandom() & 32'h7FFF_FFFF, i * 4);
    end
    idle_cycles(3);
    check("ovf_err", {31'd0, bus.o_err}, 32'd1);
    check("ovf_loaded", {31'd0, bus.o_loaded}, 32'd0);
    check("ovf_state", {29'd0, bus.o_state}, 32'd0);
    check("ovf_wr_cnt", wr_cnt - wr_base, 32'd64);
    send_byte(8'h00);
    send_byte(8'h00);
    send_byte(8'h00);
    send_byte(8'h13);
    idle_cycles(3);
    check("ovf_no_65th", wr_cnt - wr_base, 32'd64);
    check("ovf_q_empty", exp_q.size(), 32'd0);

    // 6: reset during the third byte of a word
    load_prog();
    send_byte(8'h4C);
    send_byte(8'h11);
    send_byte(8'h22);
    @(posedge clk); #1;
    bus.i_rx_valid = 1'b1;
    bus.i_rx_data  = 8'h33;
    #2;
    i_rst_n = 1'b0;
    #1;
    bus.i_rx_valid = 1'b0;
    check_reset_vals("midrst");
    idle_cycles(1);
    i_rst_n = 1'b1;
    idle_cycles(1);
    send_byte(8'h4C);
    send_word(32'hAABB_CCDD, 32'd0);
    send_word(32'hFFFF_FFFF, 32'd4);
    idle_cycles(3);
    check("fresh_loaded", {31'd0, bus.o_loaded}, 32'd1);
    check("fresh_err", {31'd0, bus.o_err}, 32'd0);
    check("fresh_q_empty", exp_q.size(), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/imem_boot_ctrl.md
Name: imem_boot_ctrl

Overview:
- Sequences the instruction-fetch stage: programs instruction memory from a UART byte stream, then gates execution.
- Drives the fetch stage's write enable, write address and write data, the halt input, and a pipeline reset.
- Accepts one-byte commands: load, run continuously, single-step.
- Sits between the UART RX and the fetch/pipeline top.

Parameters:
- NB_ADDR, 8, instruction-memory byte-address width (64 words at default).
- CMD_LOAD, 8'h4C, command byte: load program.
- CMD_RUN, 8'h43, command byte: run continuously.
- CMD_STEP, 8'h53, command byte: execute one clock.
- EOP_WORD, 32'hFFFF_FFFF, end-of-program marker word; it is written to memory as well.

Ports:
- clk  in  1  system clock.
- i_rst_n  in  1  asynchronous active-low reset.
- i_rx_valid  in  1  one-cycle strobe; i_rx_data is valid.
- i_rx_data  in  8  received byte.
- i_end_of_prog  in  1  pipeline reports the halt instruction has retired.
- o_we  out  1  instruction-memory write enable.
- o_inst_addr  out  32  write byte address; bits above NB_ADDR are 0.
- o_instr_data  out  32  write data.
- o_halt  out  1  fetch/pipeline halt.
- o_pipe_rst_n  out  1  active-low pipeline reset.
- o_loaded  out  1  a valid program is resident.
- o_err  out  1  sticky error flag.
- o_state  out  3  current FSM state, for debug.

Behaviour:
- All outputs are registered.
- Reset values: o_we=0, o_inst_addr=0, o_instr_data=0, o_halt=1, o_pipe_rst_n=0, o_loaded=0, o_err=0, state=IDLE (0).
- Reset mid-operation aborts immediately to these values. Memory contents are untouched and o_loaded is cleared.
- States: IDLE=0, LOAD=1, WRITE=2, RUN=3, STEP=4, DONE=5.
- o_halt is 1 in every state except RUN and the single STEP cycle.

IDLE:
- o_pipe_rst_n=1 once o_loaded=1.
- CMD_LOAD -> LOAD. Clears byte count, address, o_loaded and o_err. Drives o_pipe_rst_n=0.
- CMD_RUN with o_loaded=1 -> RUN.
- CMD_STEP with o_loaded=1 -> STEP.
- CMD_RUN or CMD_STEP with o_loaded=0 -> set o_err, stay in IDLE.
- Any other byte is ignored.

LOAD:
- Assembles 4 bytes big-endian: the first byte lands in [31:23+1], i.e. bits [31:24].
- On the 4th byte the word goes to o_instr_data and the FSM moves to WRITE next cycle.
- No timeout.

WRITE:
- o_we=1 for exactly one cycle at the current address. i_rx_valid is ignored in this state.
- If word == EOP_WORD: set o_loaded=1, go to IDLE, reset address to 0.
- Else if address == 2^NB_ADDR-4 (memory full, no EOP): set o_err=1, o_loaded=0, go to IDLE.
- Else: address += 4, go back to LOAD.

RUN:
- o_halt=0 and o_pipe_rst_n=1 starting the cycle after command acceptance.
- Stays until i_end_of_prog -> DONE.
- RX bytes are ignored.

STEP:
- o_halt=0 for exactly one cycle, then back to IDLE.
- If i_end_of_prog arrives in that cycle -> DONE.

DONE:
- o_halt=1.
- CMD_LOAD -> LOAD.
- CMD_RUN/CMD_STEP set o_err and remain in DONE, so the program must be reloaded.

Other rules:
- o_we is never 1 outside WRITE.
- The address never wraps silently.
- i_end_of_prog is ignored outside RUN and STEP.
- o_err is cleared only by CMD_LOAD or reset.

Test Plan:
1. Reset, then send 4C, 00 00 00 20, 00 01 08 20, FF FF FF FF.
   -> Three o_we pulses at addresses 0, 4, 8 with data 0000_0020, 0001_0820, FFFF_FFFF.
   -> o_loaded=1, o_pipe_rst_n low during load and high after.
2. Loaded, send 43.
   -> o_halt falls 1 cycle after the strobe.
   -> Assert i_end_of_prog 10 cycles later: o_halt=1 next cycle, o_state=5.
3. Loaded, send 53 three times.
   -> Exactly three one-cycle o_halt=0 pulses, state returns to 0 each time.
4. After reset, send 43 with no program loaded.
   -> o_err=1, o_halt stays 1, no o_we.
5. Send 4C followed by 64 non-EOP words.
   -> 64 writes ending at address 0xFC, then o_err=1, o_loaded=0, state IDLE, no 65th write.
6. Deassert i_rst_n during the 3rd byte of a load word, then release.
   -> All outputs at reset values.
   -> A fresh 4C load starts at address 0 with a clean byte count.
